sram_bus_bridge: RTL and testbench

Upstream front-end for the on-chip memory block. Converts the asynchronous SRAM-style parallel bus driven by the Arduino Due into single-cycle, clk-synchronous w_en/r_en requests on the memory's w_addr/r_addr/w_data/r_data interface. It also returns read data to the bus with a registered tri-state enable. One bridge per memory instance; sits between the top-level pins and the memory.

---
 rtl/sram_bus_bridge_if.sv | 35 +++
 rtl/sram_bus_bridge.sv | 170 +++++++++++++++++
 tb/tb_sram_bus_bridge.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_bridge_if.sv
// Pin-side SRAM bus and memory-side request signals of one sram_bus_bridge.
// The bridge uses the slave view; pads and memory use the master view.
interface sram_bus_bridge_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16
);
    logic              bus_cs_n;
    logic              bus_we_n;
    logic              bus_oe_n;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_din;
    logic [DATA_W-1:0] bus_dout;
    logic              bus_dout_oe;
    logic              mem_ce;
    logic              mem_ce2;
    logic              mem_lb;
    logic              mem_w_en;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_w_data;
    logic [DATA_W-1:0] mem_r_data;

    modport slave (
        input  bus_cs_n, bus_we_n, bus_oe_n, bus_addr, bus_din, mem_r_data,
        output bus_dout, bus_dout_oe, mem_ce, mem_ce2, mem_lb,
               mem_w_en, mem_r_en, mem_w_addr, mem_r_addr, mem_w_data
    );

    modport master (
        output bus_cs_n, bus_we_n, bus_oe_n, bus_addr, bus_din, mem_r_data,
        input  bus_dout, bus_dout_oe, mem_ce, mem_ce2, mem_lb,
               mem_w_en, mem_r_en, mem_w_addr, mem_r_addr, mem_w_data
    );
endinterface

// File: rtl/sram_bus_bridge.sv
// Turns asynchronous SRAM-style strobes into single-cycle synchronous memory
// requests and returns read data to the pads with a registered output enable.
module sram_bus_bridge #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_bus_bridge_if.slave   bus,
    output logic               busy,
    output logic               ovl_err
);
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_HOLD = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        RD_HOLD = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              cs_meta_q, cs_sync_q, we_meta_q, we_sync_q, oe_meta_q, oe_sync_q;
    logic              cs_meta_d, cs_sync_d, we_meta_d, we_sync_d, oe_meta_d, oe_sync_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              w_en_q, w_en_d, r_en_q, r_en_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d, dout_q, dout_d;
    logic              dout_oe_q, dout_oe_d, ovl_q, ovl_d, busy_q, busy_d;
    logic              ce_q, ce_d, lb_q, lb_d;
    logic              cs_s, wr_s, rd_s;

    assign cs_s = !cs_sync_q;
    assign wr_s = cs_s & !we_sync_q;
    assign rd_s = cs_s & !oe_sync_q & we_sync_q;

    // Next-state and next-output computation for every flop in the bridge.
    always_comb begin
        cs_meta_d = bus.bus_cs_n;
        cs_sync_d = cs_meta_q;
        we_meta_d = bus.bus_we_n;
        we_sync_d = we_meta_q;
        oe_meta_d = bus.bus_oe_n;
        oe_sync_d = oe_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_en_d    = 1'b0;
        r_en_d    = 1'b0;
        w_addr_d  = '0;
        r_addr_d  = '0;
        w_data_d  = '0;
        dout_d    = dout_q;
        dout_oe_d = 1'b0;
        ovl_d     = ovl_q;
        ce_d      = 1'b1;
        lb_d      = 1'b1;
        case (state_q)
            IDLE: begin
                if (wr_s) begin
                    state_d  = WR_REQ;
                    w_en_d   = 1'b1;
                    w_addr_d = bus.bus_addr;
                    w_data_d = bus.bus_din;
                end else if (rd_s) begin
                    state_d  = RD_REQ;
                    r_en_d   = 1'b1;
                    r_addr_d = bus.bus_addr;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_REQ: state_d = WR_HOLD;
            WR_HOLD: begin
                if (!wr_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WR_HOLD;
                end
            end
            RD_REQ: begin
                cnt_d   = CNT_W'(RD_LAT);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // A count of one here means r_data is valid in this cycle.
                if (!rd_s) begin
                    ovl_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q <= 3'd1) begin
                    cnt_d     = 3'd0;
                    dout_d    = bus.mem_r_data;
                    dout_oe_d = 1'b1;
                    state_d   = RD_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RD_HOLD: begin
                if (rd_s) begin
                    dout_oe_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; synchronizers reset to the inactive level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            we_meta_q <= 1'b1;
            we_sync_q <= 1'b1;
            oe_meta_q <= 1'b1;
            oe_sync_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            w_en_q    <= 1'b0;
            r_en_q    <= 1'b0;
            w_addr_q  <= '0;
            r_addr_q  <= '0;
            w_data_q  <= '0;
            dout_q    <= '0;
            dout_oe_q <= 1'b0;
            ovl_q     <= 1'b0;
            busy_q    <= 1'b0;
            ce_q      <= 1'b0;
            lb_q      <= 1'b0;
        end else begin
            cs_meta_q <= cs_meta_d;
            cs_sync_q <= cs_sync_d;
            we_meta_q <= we_meta_d;
            we_sync_q <= we_sync_d;
            oe_meta_q <= oe_meta_d;
            oe_sync_q <= oe_sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_en_q    <= w_en_d;
            r_en_q    <= r_en_d;
            w_addr_q  <= w_addr_d;
            r_addr_q  <= r_addr_d;
            w_data_q  <= w_data_d;
            dout_q    <= dout_d;
            dout_oe_q <= dout_oe_d;
            ovl_q     <= ovl_d;
            busy_q    <= busy_d;
            ce_q      <= ce_d;
            lb_q      <= lb_d;
        end
    end

    assign bus.bus_dout    = dout_q;
    assign bus.bus_dout_oe = dout_oe_q;
    assign bus.mem_ce      = ce_q;
    assign bus.mem_ce2     = 1'b0;
    assign bus.mem_lb      = lb_q;
    assign bus.mem_w_en    = w_en_q;
    assign bus.mem_r_en    = r_en_q;
    assign bus.mem_w_addr  = w_addr_q;
    assign bus.mem_r_addr  = r_addr_q;
    assign bus.mem_w_data  = w_data_q;
    assign busy            = busy_q;
    assign ovl_err         = ovl_q;
endmodule

// File: tb/tb_sram_bus_bridge.sv
// Directed bench for sram_bus_bridge: one RD_LAT=1 instance with a memory model
// and scoreboard, one RD_LAT=3 instance for latency and overrun behaviour.
module tb_sram_bus_bridge;
    logic clk;
    logic rst_n;
    logic busy1, ovl1, busy2, ovl2;
    int   tests = 0;
    int   fails = 0;
    int   w_pulses = 0;
    int   r_pulses = 0;
    int   oe2_cycles = 0;
    logic w_prev = 1'b0;
    logic r_prev = 1'b0;
    logic oe_prev = 1'b0;

    logic [37:0] wq [$];
    logic [21:0] rq [$];
    logic [15:0] rdq [$];
    logic [15:0] mem [256];

    sram_bus_bridge_if #(.ADDR_W(22), .DATA_W(16)) if1 ();
    sram_bus_bridge_if #(.ADDR_W(22), .DATA_W(16)) if2 ();

    sram_bus_bridge #(.ADDR_W(22), .DATA_W(16), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1), .ovl_err(ovl1));
    sram_bus_bridge #(.ADDR_W(22), .DATA_W(16), .RD_LAT(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2), .busy(busy2), .ovl_err(ovl2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with one cycle read latency for the first instance.
    always @(posedge clk) begin
        if (if1.mem_w_en) mem[if1.mem_w_addr[7:0]] <= if1.mem_w_data;
        if (if1.mem_r_en) if1.mem_r_data <= mem[if1.mem_r_addr[7:0]];
    end
    assign if2.mem_r_data = 16'h1234;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: every request pulse and read-data presentation pops an expectation.
    always @(negedge clk) begin
        if (if1.mem_w_en) begin
            w_pulses++;
            tests++;
            assert (wq.size() != 0) else begin
                fails++;
                $error("FAIL w_unexpected: observed pulse at addr %0h, expected none", if1.mem_w_addr);
            end
            if (wq.size() != 0) begin
                logic [37:0] e;
                e = wq.pop_front();
                check("w_addr", 32'(if1.mem_w_addr), 32'(e[37:16]));
                check("w_data", 32'(if1.mem_w_data), 32'(e[15:0]));
            end
        end
        if (w_prev && !if1.mem_w_en) begin
            check("w_addr_idle", 32'(if1.mem_w_addr), 32'd0);
            check("w_data_idle", 32'(if1.mem_w_data), 32'd0);
        end
        if (if1.mem_r_en) begin
            r_pulses++;
            tests++;
            assert (rq.size() != 0) else begin
                fails++;
                $error("FAIL r_unexpected: observed pulse at addr %0h, expected none", if1.mem_r_addr);
            end
            if (rq.size() != 0) check("r_addr", 32'(if1.mem_r_addr), 32'(rq.pop_front()));
        end
        if (r_prev && !if1.mem_r_en) check("r_addr_idle", 32'(if1.mem_r_addr), 32'd0);
        if (if1.bus_dout_oe && !oe_prev) begin
            tests++;
            assert (rdq.size() != 0) else begin
                fails++;
                $error("FAIL oe_unexpected: observed dout %0h, expected no drive", if1.bus_dout);
            end
            if (rdq.size() != 0) check("rd_data", 32'(if1.bus_dout), 32'(rdq.pop_front()));
        end
        if (if2.bus_dout_oe) oe2_cycles++;
        w_prev  = if1.mem_w_en;
        r_prev  = if1.mem_r_en;
        oe_prev = if1.bus_dout_oe;
    end

    task automatic do_write(input logic [21:0] a, input logic [15:0] d);
        if1.bus_cs_n = 1'b0;
        if1.bus_addr = a;
        if1.bus_din  = d;
        edges(3);
        wq.push_back({a, d});
        if1.bus_we_n = 1'b0;
        edges(5);
        if1.bus_we_n = 1'b1;
        edges(4);
        if1.bus_cs_n = 1'b1;
        edges(1);
    endtask

    task automatic do_read(input logic [21:0] a, input logic [15:0] d);
        if1.bus_cs_n = 1'b0;
        if1.bus_addr = a;
        edges(3);
        rq.push_back(a);
        rdq.push_back(d);
        if1.bus_oe_n = 1'b0;
        edges(7);
        if1.bus_oe_n = 1'b1;
        edges(4);
        if1.bus_cs_n = 1'b1;
        edges(1);
    endtask

    initial begin
        int w0, r0, c0;
        rst_n = 1'b0;
        if1.bus_cs_n = 1'b1; if1.bus_we_n = 1'b1; if1.bus_oe_n = 1'b1;
        if1.bus_addr = 22'd0; if1.bus_din = 16'd0;
        if2.bus_cs_n = 1'b1; if2.bus_we_n = 1'b1; if2.bus_oe_n = 1'b1;
        if2.bus_addr = 22'd0; if2.bus_din = 16'd0;
        @(negedge clk);
        edges(3);

        // Reset state
        check("rst_ce", 32'(if1.mem_ce), 32'd0);
        check("rst_ce2", 32'(if1.mem_ce2), 32'd0);
        check("rst_lb", 32'(if1.mem_lb), 32'd0);
        check("rst_oe", 32'(if1.bus_dout_oe), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_ovl", 32'(ovl1), 32'd0);
        rst_n = 1'b1;
        edges(1);
        check("rel_ce", 32'(if1.mem_ce), 32'd1);
        check("rel_ce2", 32'(if1.mem_ce2), 32'd0);
        check("rel_lb", 32'(if1.mem_lb), 32'd1);
        check("rel_wen", 32'(if1.mem_w_en), 32'd0);
        check("rel_ren", 32'(if1.mem_r_en), 32'd0);
        check("rel_busy", 32'(busy1), 32'd0);

        // Single write, pulse three cycles after strobe, held ten cycles
        if1.bus_cs_n = 1'b0; if1.bus_addr = 22'h00000F; if1.bus_din = 16'h00A5;
        edges(3);
        wq.push_back({22'h00000F, 16'h00A5});
        if1.bus_we_n = 1'b0;
        edges(2);
        check("wr_early", 32'(if1.mem_w_en), 32'd0);
        edges(1);
        check("wr_pulse", 32'(if1.mem_w_en), 32'd1);
        edges(7);
        check("wr_hold_busy", 32'(busy1), 32'd1);
        if1.bus_we_n = 1'b1;
        edges(4);
        check("wr_idle", 32'(busy1), 32'd0);
        check("wr_count", 32'(w_pulses), 32'd1);
        if1.bus_cs_n = 1'b1;
        edges(1);

        // Read back with the five-cycle strobe-to-drive latency
        if1.bus_cs_n = 1'b0;
        edges(3);
        rq.push_back(22'h00000F);
        rdq.push_back(16'h00A5);
        if1.bus_oe_n = 1'b0;
        edges(4);
        check("rd_oe_c4", 32'(if1.bus_dout_oe), 32'd0);
        edges(1);
        check("rd_oe_c5", 32'(if1.bus_dout_oe), 32'd1);
        check("rd_dout_c5", 32'(if1.bus_dout), 32'h00A5);
        edges(5);
        if1.bus_oe_n = 1'b1;
        edges(2);
        check("rd_oe_after2", 32'(if1.bus_dout_oe), 32'd1);
        edges(1);
        check("rd_oe_after3", 32'(if1.bus_dout_oe), 32'd0);
        check("rd_dout_keep", 32'(if1.bus_dout), 32'h00A5);
        edges(1);
        check("rd_idle", 32'(busy1), 32'd0);
        check("rd_count", 32'(r_pulses), 32'd1);
        if1.bus_cs_n = 1'b1;
        edges(1);

        // Write and output enable together: only the write happens
        w0 = w_pulses; r0 = r_pulses;
        if1.bus_cs_n = 1'b0; if1.bus_addr = 22'h000020; if1.bus_din = 16'h5A5A;
        edges(3);
        wq.push_back({22'h000020, 16'h5A5A});
        if1.bus_we_n = 1'b0; if1.bus_oe_n = 1'b0;
        edges(6);
        if1.bus_we_n = 1'b1; if1.bus_oe_n = 1'b1;
        edges(4);
        if1.bus_cs_n = 1'b1;
        edges(1);
        check("both_w", 32'(w_pulses), 32'(w0 + 1));
        check("both_r", 32'(r_pulses), 32'(r0));

        // RD_LAT=3: full read, then a strobe too short for the data
        if2.bus_cs_n = 1'b0;
        edges(3);
        if2.bus_oe_n = 1'b0;
        edges(6);
        check("l3_oe_c6", 32'(if2.bus_dout_oe), 32'd0);
        edges(1);
        check("l3_oe_c7", 32'(if2.bus_dout_oe), 32'd1);
        check("l3_dout", 32'(if2.bus_dout), 32'h1234);
        edges(3);
        if2.bus_oe_n = 1'b1;
        edges(4);
        check("l3_no_ovl", 32'(ovl2), 32'd0);
        c0 = oe2_cycles;
        if2.bus_oe_n = 1'b0;
        edges(3);
        if2.bus_oe_n = 1'b1;
        edges(4);
        check("ovl_set", 32'(ovl2), 32'd1);
        check("ovl_idle", 32'(busy2), 32'd0);
        check("ovl_dout", 32'(if2.bus_dout), 32'h1234);
        edges(10);
        check("ovl_sticky", 32'(ovl2), 32'd1);
        check("ovl_no_oe", 32'(oe2_cycles), 32'(c0));
        if2.bus_cs_n = 1'b1;
        rst_n = 1'b0;
        edges(1);
        check("ovl_clear", 32'(ovl2), 32'd0);
        rst_n = 1'b1;
        edges(2);

        // Address sweep with alternating writes and reads
        for (int a = 0; a < 256; a++) begin
            do_write(22'(a), 16'(a) ^ 16'hFFFF);
            do_read(22'(a), 16'(a) ^ 16'hFFFF);
        end
        check("sweep_w_count", 32'(w_pulses), 32'd258);
        check("sweep_r_count", 32'(r_pulses), 32'd257);
        check("wq_empty", 32'(wq.size()), 32'd0);
        check("rq_empty", 32'(rq.size()), 32'd0);
        check("rdq_empty", 32'(rdq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
